// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding doubleword load/store responder with a programmable wait latency
module dmem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

   if (LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 0..15");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [63:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [63:0]   mem_q [DEPTH];
   logic          accept;
   logic          addr_err;
   logic [AW-1:0] idx;

   assign accept   = reset && state_q == IDLE && req_valid;
   assign addr_err = |req_addr[2:0] || req_addr >= LIMIT;
   assign idx      = req_addr[AW+2:3];

   // State, wait counter and response registers; the array itself is never reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next state: wait LATENCY cycles after acceptance, then hold the response until consumed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (req_valid) begin
            state_d = (LATENCY == 0) ? RESP : WAIT;
            cnt_d   = 4'(LATENCY);
         end
         WAIT: begin
            cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            state_d = (cnt_q <= 4'd1) ? RESP : WAIT;
         end
         RESP: state_d = resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   // Response fields are captured once at acceptance and then frozen.
   always_comb begin
      err_d   = accept ? addr_err : err_q;
      rdata_d = accept ? ((req_write || addr_err) ? 64'd0 : mem_q[idx]) : rdata_q;
   end

   // Handshake outputs decode directly from the state.
   always_comb begin
      req_ready  = state_q == IDLE;
      resp_valid = state_q == RESP;
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // Byte-masked store into the addressed word at the acceptance edge.
   always_ff @(posedge clk) begin
      if (accept && req_write && !addr_err)
         for (int i = 0; i < 8; i++)
            if (req_wstrb[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of two responders (LATENCY=2 and LATENCY=0)
module tb_dmem_responder;
   localparam int unsigned DEPTH = 1024;
   localparam logic [63:0] MEMB  = 64'(DEPTH) * 64'd8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic        resp_ready = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wstrb = '0;
   logic        rdy2, rv2, re2, rdy0, rv0, re0;
   logic [63:0] rd2, rd0;
   logic        rdy, rv, re;
   logic [63:0] rd;
   logic [63:0] mdl [2][8];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rdy = sel ? rdy0 : rdy2;
   assign rv  = sel ? rv0  : rv2;
   assign re  = sel ? re0  : re2;
   assign rd  = sel ? rd0  : rd2;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & ~sel), .req_ready(rdy2), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(rv2), .resp_ready(resp_ready & ~sel), .resp_rdata(rd2), .resp_err(re2)
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & sel), .req_ready(rdy0), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(rv0), .resp_ready(resp_ready & sel), .resp_rdata(rd0), .resp_err(re0)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit bad_addr(input logic [63:0] a);
      return (a % 8 != 0) || (a >= MEMB);
   endfunction

   function automatic logic [63:0] expect_rdata(input bit wr, input logic [63:0] a);
      return (wr || bad_addr(a)) ? 64'd0 : mdl[sel][a[5:3]];
   endfunction

   // Present a request, wait for acceptance, update the model, then scramble the request inputs.
   task automatic issue(input bit wr, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, input bit busy, output bit ok);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; resp_ready = 1'b0;
      n = 0;
      while (!rdy && n < 20) begin @(negedge clk); n++; end
      check("accept_ready", rdy, 1);
      ok = rdy;
      if (!ok) begin req_valid = 1'b0; return; end
      @(posedge clk);
      if (wr && !bad_addr(a))
         for (int b = 0; b < 8; b++)
            if (s[b]) mdl[sel][a[5:3]][8*b +: 8] = d[8*b +: 8];
      #1;
      req_valid = busy; req_write = 1'($urandom); req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom}; req_wstrb = 8'($urandom);
   endtask

   task automatic xact(input bit wr, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, input int hold, input bit busy);
      int n;
      bit ok;
      logic [63:0] er;
      logic ee;
      ee = bad_addr(a);
      er = expect_rdata(wr, a);
      issue(wr, a, d, s, busy, ok);
      if (!ok) return;
      n = 0;
      do begin @(negedge clk); n++; end while (!rv && n < 40);
      check("latency", 64'(n), sel ? 64'd1 : 64'd3);
      check("resp_err", re, ee);
      check("resp_rdata", rd, er);
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", rv, 1);
         check("hold_rdata", rd, er);
         check("hold_err", re, ee);
         check("hold_req_ready", rdy, 0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("done_valid", rv, 0);
      check("done_req_ready", rdy, 1);
   endtask

   // Accept a request, then pull reset low while it is still waiting.
   task automatic xact_abort(input bit wr, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      bit ok;
      issue(wr, a, d, s, 1'b0, ok);
      if (!ok) return;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_req_ready", rdy, 1);
      check("rst_valid", rv, 0);
      check("rst_rdata", rd, 0);
      check("rst_err", re, 0);
      repeat (4) begin @(negedge clk); check("rst_hold_valid", rv, 0); end
      reset = 1'b1;
      repeat (3) begin @(negedge clk); check("post_rst_valid", rv, 0); end
   endtask

   task automatic random_phase(input int nops);
      logic [63:0] a;
      int r;
      for (int w = 0; w < 8; w++) xact(1'b1, 64'(w) * 8, {$urandom, $urandom}, 8'hFF, 0, 1'b0);
      for (int i = 0; i < nops; i++) begin
         r = $urandom_range(0, 9);
         a = 64'($urandom_range(0, 7)) * 8;
         if (r == 8) a = a | 64'($urandom_range(1, 7));
         if (r == 9) a = ($urandom_range(0, 1) == 1) ? {1'b1, 63'($urandom)} : MEMB + 64'($urandom_range(0, 500)) * 8;
         xact(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), 1'($urandom));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int t [4];
      logic [63:0] exp_s [4];
      #17;
      for (int k = 0; k < 2; k++) begin
         sel = 1'(k);
         #1;
         check("reset_req_ready", rdy, 1);
         check("reset_valid", rv, 0);
         check("reset_rdata", rd, 0);
         check("reset_err", re, 0);
      end
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      xact(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b0);
      xact(1'b0, 64'h10, 64'h0, 8'h00, 0, 1'b0);
      check("directed_load", rd, 64'hDEADBEEF_CAFEF00D);
      xact(1'b1, 64'h10, 64'h11223344_55667788, 8'h0F, 0, 1'b0);
      xact(1'b0, 64'h10, 64'h0, 8'h00, 0, 1'b0);
      check("directed_strobe", rd, 64'hDEADBEEF_55667788);
      xact(1'b0, 64'h13, 64'h0, 8'h00, 0, 1'b0);
      xact(1'b0, MEMB, 64'h0, 8'h00, 0, 1'b0);
      xact(1'b1, 64'h11, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0);
      xact(1'b1, MEMB, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0);
      xact(1'b0, 64'h10, 64'h0, 8'h00, 5, 1'b1);
      check("err_no_write", rd, 64'hDEADBEEF_55667788);
      xact(1'b0, 64'h18, 64'h0, 8'h00, 2, 1'b1);
      xact_abort(1'b0, 64'h10, 64'h0, 8'h00);
      xact(1'b0, 64'h10, 64'h0, 8'h00, 0, 1'b0);
      xact_abort(1'b1, 64'h10, 64'h0102030405060708, 8'hF0);
      xact(1'b0, 64'h10, 64'h0, 8'h00, 1, 1'b0);
      check("committed_store", rd, 64'h01020304_55667788);
      random_phase(30);
      sel = 1'b1;
      random_phase(30);
      @(negedge clk);
      for (int i = 0; i < 4; i++) exp_s[i] = mdl[1][i];
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h0; resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!rdy && n < 10) begin @(negedge clk); n++; end
         t[i] = cyc;
         @(posedge clk);
         #1;
         if (i == 3) req_valid = 1'b0;
         else req_addr = 64'(i + 1) * 8;
         @(negedge clk);
         check("stream_valid", rv, 1);
         check("stream_rdata", rd, exp_s[i]);
      end
      @(negedge clk);
      resp_ready = 1'b0;
      for (int i = 1; i < 4; i++) check("stream_gap", 64'(t[i] - t[i-1]), 64'd2);
      check("stream_idle_ready", rdy, 1);
      sel = 1'b0;
      random_phase(10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
